// File: rtl/sie_defs_pkg.sv
// Shared constants for the SIE transmit path.
//   SYNC_VALUE       : USB sync byte, used by benches as the first byte of a packet
//   IDLE_BIT         : serial level shown when no byte is loaded
//   NRZI_RESET_LEVEL : NRZI line level after reset (J state)
package sie_defs_pkg;

   localparam logic [7:0] SYNC_VALUE       = 8'h80;
   localparam logic       IDLE_BIT         = 1'b1;
   localparam logic       NRZI_RESET_LEVEL = 1'b1;

endpackage

// File: rtl/nrzi_encoder.sv
// NRZI encoder: the registered line level toggles on a 0 input and holds on a 1 input.
// Ports:
//   clk12_i : 12 MHz bit clock
//   rst_i   : asynchronous active-high reset, forces the line level high
//   data_i  : bit-stuffed serial bit
//   data_o  : registered NRZI line level (one cycle latency, never gated)
module nrzi_encoder
   import sie_defs_pkg::*;
(
   input  logic clk12_i,
   input  logic rst_i,
   input  logic data_i,
   output logic data_o
);

   logic level_q, level_d;

   always_comb begin
      level_d = data_i ? level_q : ~level_q;
   end

   always_ff @(posedge clk12_i or posedge rst_i) begin
      if (rst_i) begin
         level_q <= NRZI_RESET_LEVEL;
      end else begin
         level_q <= level_d;
      end
   end

   assign data_o = level_q;

endmodule

// File: rtl/tx_serial_encoder.sv
// Transmit serializer plus NRZI line encoder.
// Ports:
//   clk12_i       : 12 MHz bit clock
//   rst_i         : asynchronous active-high reset
//   en_i          : serializer advance enable (low during a bit-stuff insertion cycle)
//   dataValid_i   : a new byte is offered on data_i
//   data_i        : byte to serialize, LSB first
//   dataBit_o     : current serial bit (idle level when nothing is loaded)
//   bufferEmpty_o : serializer accepts a byte at the next enabled edge
//   nrziData_i    : bit-stuffed serial bit to NRZI-encode
//   nrziData_o    : registered NRZI line level
module tx_serial_encoder
   import sie_defs_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk12_i,
   input  logic                  rst_i,
   input  logic                  en_i,
   input  logic                  dataValid_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  dataBit_o,
   output logic                  bufferEmpty_o,
   input  logic                  nrziData_i,
   output logic                  nrziData_o
);

   localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

   logic [DATA_WIDTH-1:0] data_buf_q, data_buf_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  loaded_q, loaded_d;
   logic                  buffer_empty;

   // Empty while the last bit is shown so the next byte follows with no gap.
   assign buffer_empty = ~loaded_q | (cnt_q == LAST_CNT);

   always_comb begin
      data_buf_d = data_buf_q;
      cnt_d      = cnt_q;
      loaded_d   = loaded_q;
      if (en_i) begin
         if (buffer_empty) begin
            if (dataValid_i) begin
               data_buf_d = data_i;
               cnt_d      = '0;
               loaded_d   = 1'b1;
            end else begin
               loaded_d   = 1'b0;
            end
         end else begin
            data_buf_d = data_buf_q >> 1;
            cnt_d      = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk12_i or posedge rst_i) begin
      if (rst_i) begin
         data_buf_q <= '1;
         cnt_q      <= '0;
         loaded_q   <= 1'b0;
      end else begin
         data_buf_q <= data_buf_d;
         cnt_q      <= cnt_d;
         loaded_q   <= loaded_d;
      end
   end

   assign dataBit_o     = loaded_q ? data_buf_q[0] : IDLE_BIT;
   assign bufferEmpty_o = buffer_empty;

   nrzi_encoder u_nrzi (
      .clk12_i (clk12_i),
      .rst_i   (rst_i),
      .data_i  (nrziData_i),
      .data_o  (nrziData_o)
   );

endmodule

// File: tb/tb_tx_serial_encoder.sv
// Bench for tx_serial_encoder: a constant vector table from reset, hand-written
// multi-cycle sequences, then randomized traffic against a queue-based model.
module tb_tx_serial_encoder;
   import sie_defs_pkg::SYNC_VALUE;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       valid = 1'b0;
   logic [7:0] data = 8'h00;
   logic       nrzi_in = 1'b1;
   logic       data_bit, buf_empty, nrzi_out;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   tx_serial_encoder #(.DATA_WIDTH(8)) dut (
      .clk12_i       (clk),
      .rst_i         (rst),
      .en_i          (en),
      .dataValid_i   (valid),
      .data_i        (data),
      .dataBit_o     (data_bit),
      .bufferEmpty_o (buf_empty),
      .nrziData_i    (nrzi_in),
      .nrziData_o    (nrzi_out)
   );

   // Reference model: bits still to be shown for the current byte, plus the line level.
   logic m_q[$];
   logic m_lvl = 1'b1;

   function automatic logic m_bit();
      return (m_q.size() > 0) ? m_q[0] : 1'b1;
   endfunction

   function automatic logic m_empty();
      return (m_q.size() <= 1);
   endfunction

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Asserted away from a clock edge; outputs must reach reset values without an edge.
   task automatic do_reset(input string tag);
      rst = 1'b1;
      #1;
      check({tag, "_rst_bit"}, data_bit, 1'b1);
      check({tag, "_rst_empty"}, buf_empty, 1'b1);
      check({tag, "_rst_nrzi"}, nrzi_out, 1'b1);
      m_q.delete();
      m_lvl = 1'b1;
      #1;
      rst = 1'b0;
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      if (en) begin
         if (m_q.size() <= 1) begin
            m_q.delete();
            if (valid) for (int i = 0; i < 8; i++) m_q.push_back(data[i]);
         end else begin
            void'(m_q.pop_front());
         end
      end
      if (!nrzi_in) m_lvl = ~m_lvl;
      #1;
      check({tag, "_bit"}, data_bit, m_bit());
      check({tag, "_empty"}, buf_empty, m_empty());
      check({tag, "_nrzi"}, nrzi_out, m_lvl);
   endtask

   typedef struct {
      logic       en;
      logic       valid;
      logic [7:0] data;
      logic       nrzi_in;
      logic       exp_bit;
      logic       exp_empty;
      logic       exp_nrzi;
   } vec_t;

   vec_t vecs[9];

   logic [15:0] got16;
   logic [15:0] got9;

   initial begin
      // Sync byte LSB first, with the NRZI pattern 0,0,0,1,1,0 applied alongside.
      vecs[0] = '{1'b1, 1'b1, SYNC_VALUE, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 8'h00,      1'b0, 1'b0, 1'b0, 1'b1};
      vecs[2] = '{1'b1, 1'b0, 8'h00,      1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 8'h00,      1'b1, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 8'h00,      1'b1, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 8'h00,      1'b0, 1'b0, 1'b0, 1'b1};
      vecs[6] = '{1'b1, 1'b0, 8'h00,      1'b1, 1'b0, 1'b0, 1'b1};
      vecs[7] = '{1'b1, 1'b0, 8'h00,      1'b1, 1'b1, 1'b1, 1'b1};
      vecs[8] = '{1'b1, 1'b0, 8'h00,      1'b1, 1'b1, 1'b1, 1'b1};

      repeat (2) @(posedge clk);
      #1;
      do_reset("tbl");
      for (int i = 0; i < 9; i++) begin
         en      = vecs[i].en;
         valid   = vecs[i].valid;
         data    = vecs[i].data;
         nrzi_in = vecs[i].nrzi_in;
         step($sformatf("tbl%0d", i));
         check($sformatf("tbl%0d_cbit", i), data_bit, vecs[i].exp_bit);
         check($sformatf("tbl%0d_cempty", i), buf_empty, vecs[i].exp_empty);
         check($sformatf("tbl%0d_cnrzi", i), nrzi_out, vecs[i].exp_nrzi);
      end

      // Back-to-back bytes with valid held high.
      do_reset("b2b");
      en = 1'b1;
      nrzi_in = 1'b1;
      got16 = '0;
      for (int i = 0; i < 16; i++) begin
         valid = 1'b1;
         data  = (i == 0) ? SYNC_VALUE : 8'hC3;
         step("b2b");
         got16 = {got16[14:0], data_bit};
         check($sformatf("b2b%0d_cempty", i), buf_empty, (i == 7) || (i == 15));
      end
      valid = 1'b0;
      step("b2b_end");
      check("b2b_idle_bit", data_bit, 1'b1);
      check("b2b_idle_empty", buf_empty, 1'b1);
      check16("b2b_stream", got16, 16'b0000000111000011);

      // One stall cycle while bit 2 of 8'h01 is shown.
      do_reset("stall");
      data = 8'h01;
      got9 = '0;
      for (int i = 0; i < 9; i++) begin
         en    = (i != 3);
         valid = (i == 0);
         step("stall");
         got9 = {got9[14:0], data_bit};
         check($sformatf("stall%0d_cempty", i), buf_empty, (i == 8));
      end
      en = 1'b1;
      valid = 1'b0;
      step("stall_end");
      check16("stall_stream", got9, 16'b0000000100000000);

      // Reset in the middle of 8'hAA, then a fresh byte starts at bit 0.
      do_reset("mid");
      en = 1'b1;
      valid = 1'b1;
      data = 8'hAA;
      step("mid");
      valid = 1'b0;
      repeat (4) step("mid");
      check("mid_bit4", data_bit, 1'b0);
      check("mid_empty4", buf_empty, 1'b0);
      do_reset("mid_abort");
      valid = 1'b1;
      data = 8'h0F;
      step("mid_new");
      check("mid_new_bit0", data_bit, 1'b1);
      valid = 1'b0;
      for (int i = 0; i < 8; i++) step("mid_tail");
      check("mid_tail_idle", data_bit, 1'b1);

      // Randomized traffic with occasional stalls and asynchronous resets.
      for (int n = 0; n < 1500; n++) begin
         en      = ($urandom_range(0, 9) != 0);
         valid   = $urandom_range(0, 1);
         data    = 8'($urandom);
         nrzi_in = $urandom_range(0, 1);
         step("rnd");
         if ($urandom_range(0, 149) == 0) do_reset("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tx_serial_encoder.md
TX_SERIAL_ENCODER -- requirements
Module: tx_serial_encoder

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, serializer byte width; all behaviour below is specified for the default of 8.
REQ-002 clk12_i  input  1  single 12 MHz bit clock; all state changes on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 en_i  input  1  serializer advance enable; low = bit-stuff insertion cycle, serializer holds.
REQ-005 dataValid_i  input  1  new byte offered on data_i.
REQ-006 data_i  input  8  byte to serialize, LSB first.
REQ-007 dataBit_o  output  1  current serial bit; feeds CRC and bit stuffer.
REQ-008 bufferEmpty_o  output  1  high = serializer accepts a byte at the next qualifying edge.
REQ-009 nrziData_i  input  1  bit-stuffed serial bit to encode.
REQ-010 nrziData_o  output  1  registered NRZI line level.

Function
REQ-011 Serializer state SHALL be byte register buf[7:0], bit counter cnt[2:0] and flag loaded.
REQ-012 dataBit_o SHALL be buf[0] when loaded=1, else 1 (idle).
REQ-013 bufferEmpty_o SHALL be combinational: ~loaded | (cnt==7).
REQ-014 With en_i=0, buf, cnt and loaded SHALL hold; dataValid_i is ignored and no byte is loaded.
REQ-015 With en_i=1, bufferEmpty_o=1 and dataValid_i=1: buf<=data_i, cnt<=0, loaded<=1.
REQ-016 With en_i=1, bufferEmpty_o=1 and dataValid_i=0: loaded<=0.
REQ-017 With en_i=1 and bufferEmpty_o=0: buf<=buf>>1, cnt<=cnt+1.
REQ-018 Latency: a byte loaded at edge N drives bit k on dataBit_o after edge N+k, k=0..7, with en_i high throughout.
REQ-019 bufferEmpty_o SHALL be high while bit 7 is shown, so a byte loaded at edge N+8 follows with no gap.
REQ-020 A low en_i cycle SHALL extend the current bit by exactly one cycle per low cycle.
REQ-021 NRZI: at each edge, nrziData_o SHALL toggle when nrziData_i=0 and hold when nrziData_i=1.
REQ-022 NRZI latency SHALL be one cycle; it SHALL NOT be gated by en_i.
REQ-023 Width rule: cnt wraps 7->0 only via a load; no arithmetic beyond the 3-bit increment.

Reset
REQ-024 rst_i high SHALL immediately force loaded=0, cnt=0, buf=8'hFF and nrziData_o=1, giving dataBit_o=1 and bufferEmpty_o=1.
REQ-025 While rst_i is high, all inputs SHALL be ignored.
REQ-026 After rst_i is released, the first rising edge SHALL process inputs normally.
REQ-027 A reset mid-byte SHALL discard the remaining bits; no pending load survives.

Structure
REQ-028 No new package types are needed.
REQ-029 Benches SHALL take SYNC_VALUE (8'h80) from sie_defs_pkg.
REQ-030 The NRZI stage SHALL be sub-module nrzi_encoder (clk12_i, rst_i, data_i, data_o).
REQ-031 The serializer SHALL be implemented inline in the top-level module.

Verification
REQ-032 Reset: assert rst_i -> dataBit_o=1, bufferEmpty_o=1, nrziData_o=1 without a clock edge.
REQ-033 Load 8'h80, en_i=1 -> dataBit_o 0,0,0,0,0,0,0,1; bufferEmpty_o high only during the eighth bit.
REQ-034 Back-to-back 8'h80 then 8'hC3 with dataValid_i held -> 16 contiguous bits 0000000111000011, then dataBit_o=1 and bufferEmpty_o=1.
REQ-035 8'h01 with en_i low for 1 cycle after bit 2 -> bit 2 (value 0) held 2 cycles; 9-cycle sequence otherwise intact.
REQ-036 NRZI from reset: nrziData_i 0,0,0,1,1,0 -> nrziData_o 0,1,0,0,0,1 one cycle later.
REQ-037 Async reset after bit 3 of 8'hAA -> outputs at reset values immediately; next load starts at bit 0.
